// File: rtl/c432_lock_pkg.sv
// Shared constants and types for the c432 key-loading path.
package c432_lock_pkg;
  localparam int XOR_KEYS   = 41;
  localparam int MUX_KEYS   = 4;
  localparam int KEY_W      = XOR_KEYS + MUX_KEYS;
  localparam int CRC_W      = 8;
  localparam int FRAME_BITS = KEY_W + CRC_W;
  localparam logic [CRC_W-1:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_ARMED = 3'd3,
    ST_FAIL  = 3'd4
  } loader_state_e;
endpackage

// File: rtl/c432_key_loader_crc8.sv
// Bit-serial CRC-8 with MSB feedback, zero init, no reflection, no final XOR.
module crc8_serial
  import c432_lock_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);
  logic [CRC_W-1:0] crc_q, crc_d;
  logic             fb;

  always_comb begin
    fb    = crc_q[CRC_W-1] ^ din;
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC8_POLY : '0);
    end
  end

  always_ff @(posedge clk) begin
    crc_q <= crc_d;
  end

  assign crc = crc_q;
endmodule

// File: rtl/c432_key_loader.sv
// Serially loads a 45-bit unlock key plus CRC-8, verifies it, then drives the c432 key gates.
module c432_key_loader
  import c432_lock_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);
  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_LOAD  = ST_LOAD;
  localparam logic [2:0] S_CHECK = ST_CHECK;
  localparam logic [2:0] S_ARMED = ST_ARMED;
  localparam logic [2:0] S_FAIL  = ST_FAIL;

  logic [2:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [CRC_W-1:0] rx_crc_q, rx_crc_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             err_q, err_d;
  logic             accept, crc_clr, crc_en;
  logic [CRC_W-1:0] calc_crc;

  assign accept = (state_q == S_LOAD) && ser_valid;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    rx_crc_d    = rx_crc_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          cnt_d    = '0;
          shadow_d = '0;
          err_d    = 1'b0;
          crc_clr  = 1'b1;
        end
      end
      S_LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + 6'd1;
          // Right-shifting inserts at the top, so after all bits arrive bit n sits at index n.
          if (cnt_q < 6'(KEY_W)) begin
            shadow_d = {ser_data, shadow_q[KEY_W-1:1]};
            crc_en   = 1'b1;
          end else begin
            rx_crc_d = {ser_data, rx_crc_q[CRC_W-1:1]};
          end
          if (cnt_q == 6'(FRAME_BITS - 1)) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (calc_crc == rx_crc_q) begin
          state_d     = S_ARMED;
          key_d       = shadow_q;
          key_valid_d = 1'b1;
        end else begin
          state_d = S_FAIL;
          err_d   = 1'b1;
        end
      end
      S_ARMED, S_FAIL: begin
        if (start) begin
          state_d     = S_LOAD;
          cnt_d       = '0;
          shadow_d    = '0;
          key_d       = '0;
          key_valid_d = 1'b0;
          err_d       = 1'b0;
          crc_clr     = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        key_d       = '0;
        key_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
    end
    shadow_q <= shadow_d;
    rx_crc_q <= rx_crc_d;
  end

  crc8_serial u_crc (
    .clk (clk),
    .clr (crc_clr | rst),
    .en  (crc_en),
    .din (ser_data),
    .crc (calc_crc)
  );

  assign ser_ready = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign key_out   = key_q;
  assign key_valid = key_valid_q;
  assign err       = err_q;
endmodule

// File: tb/tb_c432_key_loader.sv
// Directed bench for c432_key_loader: framing, CRC check, re-key, reset and boundary cases.
module tb_c432_key_loader;
  import c432_lock_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             ser_valid = 1'b0;
  logic             ser_data = 1'b0;
  logic             ser_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic             err;

  int checks = 0;
  int errors = 0;

  logic [KEY_W-1:0] k3, k5, k6;

  c432_key_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .ser_ready (ser_ready),
    .key_out   (key_out),
    .key_valid (key_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] crc8(input logic [KEY_W-1:0] k);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < KEY_W; i++) begin
      fb = c[7] ^ k[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    ser_valid = 1'b1;
    ser_data  = b;
    @(negedge clk);
    ser_valid = 1'b0;
  endtask

  // Returns at the falling edge right after the 53rd bit is accepted (loader in CHECK).
  task automatic send_frame(input logic [KEY_W-1:0] k, input logic [7:0] c,
                            input bit gaps, input bit chk_zero, input bit mid_start);
    for (int i = 0; i < KEY_W; i++) begin
      if (mid_start && (i == 10 || i == 30)) start = 1'b1;
      send_bit(k[i], gaps);
      start = 1'b0;
      if (chk_zero) check("key_out_zero_during_load", 64'(key_out), 64'h0);
    end
    for (int i = 0; i < CRC_W; i++) send_bit(c[i], gaps);
  endtask

  initial begin
    k3 = '1;
    k5 = 45'h0A5A5A5A5A5;
    k6 = 45'h123456789AB;

    // Power-on reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_key_out", 64'(key_out), 64'h0);
    check("rst_key_valid", 64'(key_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check("rst_ser_ready", 64'(ser_ready), 64'h0);
    rst = 1'b0;

    // ser_valid in IDLE is ignored
    ser_valid = 1'b1;
    ser_data  = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ser_ready", 64'(ser_ready), 64'h0);
    check("idle_busy", 64'(busy), 64'h0);
    ser_valid = 1'b0;

    // T1: reset in the middle of random traffic, with start held alongside rst
    pulse_start();
    check("t1_load_busy", 64'(busy), 64'h1);
    check("t1_load_ready", 64'(ser_ready), 64'h1);
    repeat (10) begin
      ser_valid = 1'($urandom);
      ser_data  = 1'($urandom);
      @(negedge clk);
    end
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) begin
      ser_valid = 1'($urandom);
      ser_data  = 1'($urandom);
      @(negedge clk);
    end
    rst       = 1'b0;
    start     = 1'b0;
    ser_valid = 1'b0;
    check("t1_key_out", 64'(key_out), 64'h0);
    check("t1_key_valid", 64'(key_valid), 64'h0);
    check("t1_err", 64'(err), 64'h0);
    check("t1_busy", 64'(busy), 64'h0);
    check("t1_ser_ready", 64'(ser_ready), 64'h0);

    // T2: all-zero key, CRC 0x00, no gaps
    pulse_start();
    send_frame('0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("t2_check_busy", 64'(busy), 64'h1);
    check("t2_check_ready", 64'(ser_ready), 64'h0);
    check("t2_check_key_valid", 64'(key_valid), 64'h0);
    @(negedge clk);
    check("t2_key_valid", 64'(key_valid), 64'h1);
    check("t2_key_out", 64'(key_out), 64'h0);
    check("t2_busy", 64'(busy), 64'h0);
    check("t2_err", 64'(err), 64'h0);

    // T3: all-ones key with random gaps (re-key from ARMED)
    pulse_start();
    check("t3_rekey_key_valid", 64'(key_valid), 64'h0);
    send_frame(k3, crc8(k3), 1'b1, 1'b0, 1'b0);
    check("t3_check_key_valid", 64'(key_valid), 64'h0);
    @(negedge clk);
    check("t3_key_valid", 64'(key_valid), 64'h1);
    check("t3_key_out", 64'(key_out), 64'h1FFF_FFFF_FFFF);
    check("t3_x1", 64'(key_out[0]), 64'h1);
    check("t3_p4", 64'(key_out[44]), 64'h1);

    // T4: same frame, rx_crc bit 0 flipped
    pulse_start();
    send_frame(k3, crc8(k3) ^ 8'h01, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_err", 64'(err), 64'h1);
    check("t4_key_out", 64'(key_out), 64'h0);
    check("t4_key_valid", 64'(key_valid), 64'h0);
    check("t4_busy", 64'(busy), 64'h0);
    repeat (3) @(negedge clk);
    check("t4_err_sticky", 64'(err), 64'h1);
    pulse_start();
    check("t4_restart_err", 64'(err), 64'h0);
    check("t4_restart_busy", 64'(busy), 64'h1);
    send_frame(k3, crc8(k3), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_rearm_key_valid", 64'(key_valid), 64'h1);

    // T5: re-key from ARMED with start pulses during load
    pulse_start();
    check("t5_rekey_key_out", 64'(key_out), 64'h0);
    check("t5_rekey_key_valid", 64'(key_valid), 64'h0);
    send_frame(k5, crc8(k5), 1'b1, 1'b1, 1'b1);
    check("t5_check_key_out", 64'(key_out), 64'h0);
    @(negedge clk);
    check("t5_key_out", 64'(key_out), 64'(k5));
    check("t5_key_valid", 64'(key_valid), 64'h1);
    check("t5_err", 64'(err), 64'h0);

    // T6: reset after 31 bits, then a complete valid frame
    pulse_start();
    for (int i = 0; i < 31; i++) send_bit(k3[i], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_busy", 64'(busy), 64'h0);
    check("t6_rst_key_out", 64'(key_out), 64'h0);
    check("t6_rst_key_valid", 64'(key_valid), 64'h0);
    pulse_start();
    send_frame(k6, crc8(k6), 1'b0, 1'b0, 1'b0);
    check("t6_check_busy", 64'(busy), 64'h1);
    @(negedge clk);
    check("t6_key_out", 64'(key_out), 64'(k6));
    check("t6_key_valid", 64'(key_valid), 64'h1);
    check("t6_err", 64'(err), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
